// File: rtl/register_bus_controller.sv
// Bus-cycle sequencer between the 68030 local bus and memory-mapped register slaves.
// It decodes the slave index, drives chip select, a write strobe and DSACK/BERR, and captures read data.
module register_bus_controller #(
    parameter int SLAVE_BITS     = 2,
    parameter int WAIT_STATES    = 1,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int NUM_SLAVES    = 2**SLAVE_BITS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_as_n,
    input  logic                    cpu_rw,
    input  logic                    cpu_select,
    input  logic [SLAVE_BITS-1:0]   cpu_addr,
    input  logic [NUM_SLAVES-1:0]   slave_port32,
    input  logic [NUM_SLAVES-1:0]   slave_ready,
    input  logic [NUM_SLAVES*32-1:0] slave_data,
    output logic [NUM_SLAVES-1:0]   cs,
    output logic                    write,
    output logic [31:0]             cpu_data_out,
    output logic [1:0]              dsack_n,
    output logic                    berr_n,
    output logic                    busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        ACK,
        BERR
    } state_t;

    state_t                  state_q, state_d;
    logic [SLAVE_BITS-1:0]   idx_q, idx_d;
    logic                    rw_q, rw_d;
    logic                    p32_q, p32_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [NUM_SLAVES-1:0]   cs_q, cs_d;
    logic                    write_q, write_d;
    logic [31:0]             data_q, data_d;
    logic [1:0]              dsack_q, dsack_d;
    logic                    berr_q, berr_d;
    logic                    busy_q, busy_d;
    logic [31:0]             rd_word;

    assign rd_word = slave_data[32*int'(idx_q) +: 32];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        p32_d   = p32_q;
        wcnt_d  = wcnt_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        write_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cpu_as_n && cpu_select) begin
                    idx_d   = cpu_addr;
                    rw_d    = cpu_rw;
                    p32_d   = slave_port32[cpu_addr];
                    write_d = ~cpu_rw;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d  = 4'(WAIT_STATES);
                    tmo_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Ready beats timeout when both land on the same edge.
                if (cpu_as_n) begin
                    state_d = IDLE;
                end else if (wcnt_q == 4'd0 && slave_ready[idx_q]) begin
                    state_d = ACK;
                    if (rw_q) begin
                        data_d = p32_q ? rd_word : {rd_word[15:0], 16'h0000};
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = BERR;
                end else begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ACK, BERR: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with it.
        busy_d  = (state_d != IDLE);
        cs_d    = (state_d == ACCESS || state_d == WAIT || state_d == ACK)
                  ? (NUM_SLAVES'(1) << idx_d) : '0;
        dsack_d = (state_d == ACK) ? {1'b0, ~p32_d} : 2'b11;
        berr_d  = (state_d != BERR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rw_q    <= 1'b1;
            p32_q   <= 1'b0;
            wcnt_q  <= '0;
            tmo_q   <= '0;
            cs_q    <= '0;
            write_q <= 1'b0;
            data_q  <= '0;
            dsack_q <= 2'b11;
            berr_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            p32_q   <= p32_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
            cs_q    <= cs_d;
            write_q <= write_d;
            data_q  <= data_d;
            dsack_q <= dsack_d;
            berr_q  <= berr_d;
            busy_q  <= busy_d;
        end
    end

    assign cs           = cs_q;
    assign write        = write_q;
    assign cpu_data_out = data_q;
    assign dsack_n      = dsack_q;
    assign berr_n       = berr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_register_bus_controller.sv
// Self-checking bench for register_bus_controller: an age-based cycle model checked every cycle,
// plus directed accesses with hand-computed latencies and data.
module tb_register_bus_controller;

    localparam int SB = 2;
    localparam int WS = 1;
    localparam int TO = 64;
    localparam int NS = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_as_n = 1'b1;
    logic              cpu_rw = 1'b1;
    logic              cpu_select = 1'b0;
    logic [SB-1:0]     cpu_addr = '0;
    logic [NS-1:0]     slave_port32 = 4'b0011;
    logic [NS-1:0]     slave_ready = 4'b1111;
    logic [NS*32-1:0]  slave_data = '0;
    logic [NS-1:0]     cs;
    logic              write;
    logic [31:0]       cpu_data_out;
    logic [1:0]        dsack_n;
    logic              berr_n;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    register_bus_controller #(
        .SLAVE_BITS(SB),
        .WAIT_STATES(WS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cpu_as_n(cpu_as_n),
        .cpu_rw(cpu_rw),
        .cpu_select(cpu_select),
        .cpu_addr(cpu_addr),
        .slave_port32(slave_port32),
        .slave_ready(slave_ready),
        .slave_data(slave_data),
        .cs(cs),
        .write(write),
        .cpu_data_out(cpu_data_out),
        .dsack_n(dsack_n),
        .berr_n(berr_n),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a cycle is described by its age in edges since acceptance; WAIT edge number
    // (age-1) doubles as elapsed wait and timeout count.
    bit          m_active = 0, m_ack = 0, m_berr = 0, m_rw = 1, m_p32 = 0;
    int          m_idx = 0, m_age = 0;
    logic [31:0] m_data = '0;
    logic [31:0] m_word;

    always @(posedge clock) begin
        if (reset) begin
            m_active = 0; m_ack = 0; m_berr = 0; m_age = 0; m_data = '0;
        end else if (!m_active) begin
            if (!cpu_as_n && cpu_select) begin
                m_active = 1; m_ack = 0; m_berr = 0; m_age = 0;
                m_idx = int'(cpu_addr); m_rw = cpu_rw; m_p32 = slave_port32[cpu_addr];
            end
        end else if (m_ack || m_berr) begin
            if (cpu_as_n) m_active = 0;
        end else if (cpu_as_n) begin
            m_active = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (m_age - 1 >= WS && slave_ready[m_idx]) begin
            m_ack = 1;
            if (m_rw) begin
                m_word = slave_data[32*m_idx +: 32];
                m_data = m_p32 ? m_word : {m_word[15:0], 16'h0000};
            end
        end else if (m_age - 1 == TO - 1) begin
            m_berr = 1;
        end else begin
            m_age++;
        end
    end

    always @(posedge clock) begin
        logic [31:0] e_cs;
        #1;
        e_cs = (m_active && !m_berr) ? (32'd1 << m_idx) : 32'd0;
        chk("m_busy", {31'd0, busy}, {31'd0, m_active});
        chk("m_cs", {28'd0, cs}, e_cs);
        chk("m_write", {31'd0, write}, {31'd0, (m_active && m_age == 0 && !m_rw && !m_ack && !m_berr)});
        chk("m_dsack", {30'd0, dsack_n}, (m_active && m_ack) ? (m_p32 ? 32'd0 : 32'd1) : 32'd3);
        chk("m_berr", {31'd0, berr_n}, {31'd0, !(m_active && m_berr)});
        chk("m_data", cpu_data_out, m_data);
    end

    task automatic start(input int idx, input bit rw);
        @(negedge clock);
        cpu_as_n = 1'b0;
        cpu_select = 1'b1;
        cpu_addr = SB'(idx);
        cpu_rw = rw;
    endtask

    // Runs an access; edges is counted from the accept edge (0 = accept edge).
    task automatic run(input int idx, input bit rw, output int edges, output int wr_hi,
                       output logic [NS-1:0] cs0);
        start(idx, rw);
        edges = -1;
        wr_hi = 0;
        cs0 = '0;
        do begin
            @(posedge clock);
            #1;
            edges++;
            if (edges == 0) cs0 = cs;
            if (write === 1'b1) wr_hi++;
        end while (dsack_n === 2'b11 && berr_n === 1'b1 && edges < 200);
    endtask

    task automatic end_cycle();
        @(negedge clock);
        cpu_as_n = 1'b1;
        cpu_select = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("watchdog expired at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int edges, wr_hi;
        logic [NS-1:0] cs0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_cs", {28'd0, cs}, 32'd0);
        chk("rst_dsack", {30'd0, dsack_n}, 32'd3);
        chk("rst_berr", {31'd0, berr_n}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", cpu_data_out, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // 32-bit write to slave 1
        run(1, 1'b0, edges, wr_hi, cs0);
        chk("wr_cs0", {28'd0, cs0}, 32'h2);
        chk("wr_latency", edges, 32'd3);
        chk("wr_strobes", wr_hi, 32'd1);
        chk("wr_dsack", {30'd0, dsack_n}, 32'd0);
        chk("wr_data", cpu_data_out, 32'd0);
        end_cycle();
        chk("wr_idle_busy", {31'd0, busy}, 32'd0);
        chk("wr_idle_cs", {28'd0, cs}, 32'd0);

        // 16-bit read from slave 2
        slave_data[95:64] = 32'h1234ABCD;
        run(2, 1'b1, edges, wr_hi, cs0);
        chk("rd16_latency", edges, 32'd3);
        chk("rd16_dsack", {30'd0, dsack_n}, 32'd1);
        chk("rd16_data", cpu_data_out, 32'hABCD0000);
        chk("rd16_strobes", wr_hi, 32'd0);
        end_cycle();

        // 32-bit read with ready withheld until it is sampled at E8
        slave_data[31:0] = 32'hCAFEF00D;
        slave_ready[0] = 1'b0;
        fork
            begin
                repeat (9) @(negedge clock);
                slave_ready[0] = 1'b1;
            end
        join_none
        run(0, 1'b1, edges, wr_hi, cs0);
        chk("rdy_latency", edges, 32'd8);
        chk("rdy_data", cpu_data_out, 32'hCAFEF00D);
        end_cycle();

        // Ready never arrives: bus error after 64 WAIT cycles
        slave_ready[3] = 1'b0;
        run(3, 1'b1, edges, wr_hi, cs0);
        chk("to_latency", edges, 32'd65);
        chk("to_berr", {31'd0, berr_n}, 32'd0);
        chk("to_cs", {28'd0, cs}, 32'd0);
        chk("to_dsack", {30'd0, dsack_n}, 32'd3);
        chk("to_data", cpu_data_out, 32'hCAFEF00D);
        end_cycle();
        chk("to_idle_berr", {31'd0, berr_n}, 32'd1);

        // Ready lands on the timeout edge: acknowledge wins
        slave_data[127:96] = 32'h0000BEEF;
        fork
            begin
                repeat (66) @(negedge clock);
                slave_ready[3] = 1'b1;
            end
        join_none
        run(3, 1'b1, edges, wr_hi, cs0);
        chk("tie_latency", edges, 32'd65);
        chk("tie_dsack", {30'd0, dsack_n}, 32'd1);
        chk("tie_berr", {31'd0, berr_n}, 32'd1);
        chk("tie_data", cpu_data_out, 32'hBEEF0000);
        end_cycle();

        // Abort in WAIT, then a normal write
        slave_ready[0] = 1'b0;
        start(0, 1'b1);
        repeat (3) @(negedge clock);
        cpu_as_n = 1'b1;
        cpu_select = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cs", {28'd0, cs}, 32'd0);
        chk("abort_dsack", {30'd0, dsack_n}, 32'd3);
        slave_ready[0] = 1'b1;
        run(1, 1'b0, edges, wr_hi, cs0);
        chk("post_abort_latency", edges, 32'd3);
        chk("post_abort_strobes", wr_hi, 32'd1);
        end_cycle();

        // Reset during ACK
        slave_data[31:0] = 32'h55AA0FF0;
        run(0, 1'b1, edges, wr_hi, cs0);
        chk("pre_rst_data", cpu_data_out, 32'h55AA0FF0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("ackrst_busy", {31'd0, busy}, 32'd0);
        chk("ackrst_cs", {28'd0, cs}, 32'd0);
        chk("ackrst_dsack", {30'd0, dsack_n}, 32'd3);
        chk("ackrst_berr", {31'd0, berr_n}, 32'd1);
        chk("ackrst_write", {31'd0, write}, 32'd0);
        chk("ackrst_data", cpu_data_out, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        cpu_as_n = 1'b1;
        cpu_select = 1'b0;
        repeat (2) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_bus_controller.md
# register_bus_controller

Bus-cycle sequencer between the 68030 local bus and the board's memory-mapped register slaves (16-bit and 32-bit register blocks). It decodes the slave index, drives one-hot chip selects and a single-cycle write strobe, inserts programmable wait states, and honours per-slave ready. It returns 68030 DSACK port-size acknowledges and captures read data, or raises BERR on a slave timeout.

## Interface
- SLAVE_BITS, 2, slave index width; NUM_SLAVES = 2**SLAVE_BITS
- WAIT_STATES, 1, minimum extra cycles in WAIT before acknowledge (0..15)
- TIMEOUT_CYCLES, 64, WAIT cycles before bus error; must exceed WAIT_STATES
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cpu_as_n  in  1  address strobe, active-low, already synchronised to clock
- cpu_rw  in  1  1 = read, 0 = write; sampled with AS
- cpu_select  in  1  region decode from glue logic, active-high
- cpu_addr  in  SLAVE_BITS  slave index
- slave_port32  in  NUM_SLAVES  per slave: 1 = 32-bit port, 0 = 16-bit port
- slave_ready  in  NUM_SLAVES  per slave ready, active-high
- slave_data  in  NUM_SLAVES*32  concatenated slave read data; slave i at [32i+31:32i]
- cs  out  NUM_SLAVES  one-hot chip select
- write  out  1  write strobe, one cycle per write access
- cpu_data_out  out  32  captured read data
- dsack_n  out  2  68030 DSACK[1:0], active-low
- berr_n  out  1  bus error, active-low
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, WAIT, ACK, BERR.
- IDLE: if cpu_as_n==0 and cpu_select==1, latch index, rw, and port size, then go to ACCESS. Otherwise stay.
- ACCESS (1 cycle):
  - cs[index]=1.
  - write = ~rw for this cycle only.
  - Load wait counter with WAIT_STATES and clear timeout counter.
  - Go to WAIT.
- WAIT:
  - cs held and write=0.
  - Wait counter decrements to 0 and saturates.
  - Timeout counter increments every cycle.
  - If wait counter==0 and slave_ready[index]==1, go to ACK. Read data is captured on this edge.
  - Else if the timeout counter reaches TIMEOUT_CYCLES-1, go to BERR.
- ACK:
  - cs held.
  - dsack_n = 2'b00 for a 32-bit slave, 2'b01 for a 16-bit slave.
  - Hold until cpu_as_n==1 is sampled, then go to IDLE.
- BERR: cs=0 and berr_n=0. Hold until cpu_as_n==1 is sampled, then go to IDLE.
- Read capture:
  - 32-bit slave: cpu_data_out = slave_data word.
  - 16-bit slave: cpu_data_out = {slave[15:0], 16'h0000}, so the data sits on D31–D16.
  - Writes leave cpu_data_out unchanged.
- Abort: cpu_as_n==1 sampled in ACCESS or WAIT returns to IDLE at that edge. cs drops, no DSACK is asserted, and no further write strobe occurs.
- Back-to-back cycles: an access is accepted only from IDLE. A new cycle needs one IDLE cycle with AS sampled asserted.
- Index out of range cannot occur, because the slave count is a power of two.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE
  - cs = 0, write = 0, busy = 0
  - dsack_n = 2'b11, berr_n = 1
  - cpu_data_out = 0
- Reset asserted mid-cycle returns everything to the reset values on the next edge, in any state.
- Latency:
  - AS sampled at edge E0: cs/write valid after E0.
  - WAIT is entered at E1.
  - With ready held, dsack_n asserts after edge E(2+WAIT_STATES).
  - WAIT_STATES=0 gives DSACK in the 3rd cycle after the AS sample.
- Deassertion: dsack_n/berr_n/cs/busy deassert on the same edge that samples cpu_as_n==1.
- A slave_ready drop during WAIT extends WAIT. Ready is ignored in ACK.
- Timeout: berr_n asserts after exactly TIMEOUT_CYCLES cycles in WAIT without a successful exit. Ready arriving on that same edge wins, and the controller goes to ACK.

## Test plan
- 32-bit write, WAIT_STATES=1, index 1, ready=1 -> cs=4'b0010 from the cycle after AS, write high exactly 1 cycle, dsack_n=00 two cycles later, all clear after AS negation.
- 16-bit read, index 2, slave data 32'h1234ABCD -> cpu_data_out=32'hABCD0000, dsack_n=01, write never high.
- Ready withheld 5 cycles on a 32-bit read -> WAIT extended 5 cycles, DSACK on the cycle after ready returns, data captured then.
- Ready never asserted, TIMEOUT_CYCLES=64 -> berr_n=0 after 64 WAIT cycles, cs=0, dsack_n=11 throughout, IDLE after AS negation.
- AS negated in WAIT -> immediate IDLE, no DSACK, a subsequent access completes normally.
- Reset asserted during ACK -> next edge: all outputs at reset values, cpu_data_out=0, busy=0.
